// File: rtl/bmf_basis_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bmf_basis_decoder: rebuilds M-bit words from K-bit latent codes using a    |
// | run-time basis H. Define BMF_GF2_EN for XOR (GF(2)) row combination.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bmf_basis_decoder #(
  parameter int K  = 3,
  parameter int M  = 4,
  parameter int CW = 16,
  localparam int RW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [RW-1:0] cfg_row,
  input  logic [M-1:0]  cfg_data,
  input  logic          cfg_commit,
  input  logic          cfg_reopen,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One extra bit so K itself is representable for the row-range test.
  localparam logic [RW:0] K_LIM = (RW + 1)'(K);

  state_t        state_q, state_d;
  logic [M-1:0]  h_q [K];
  logic [M-1:0]  h_d [K];
  logic [M-1:0]  p_q [K];
  logic [M-1:0]  p_d [K];
  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic [M-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] count_q, count_d;
  logic          cfg_err_q, cfg_err_d;

  logic          s2_free;
  logic          accept;
  logic          deliver;
  logic          cfg_wr_ok;
  logic [M-1:0]  combined;

  assign s2_free   = !s2_valid_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && (!s1_valid_q || s2_free);
  assign accept    = in_valid && in_ready;
  assign deliver   = s2_valid_q && out_ready;
  assign cfg_wr_ok = cfg_we && (state_q == ST_CFG) && ({1'b0, cfg_row} < K_LIM);

  always_comb begin
    combined = '0;
    for (int r = 0; r < K; r++) begin
`ifdef BMF_GF2_EN
      combined = combined ^ p_q[r];
`else
      combined = combined | p_q[r];
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    p_d        = p_q;
    s1_valid_d = accept || (s1_valid_q && !s2_free);
    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
    out_data_d = out_data_q;
    count_d    = count_q;
    cfg_err_d  = cfg_err_q;

    if (cfg_we && !cfg_wr_ok) cfg_err_d = 1'b1;
    if (cfg_wr_ok) h_d[cfg_row] = cfg_data;

    if (accept) begin
      for (int r = 0; r < K; r++) p_d[r] = h_q[r] & {M{in_code[r]}};
    end

    // out_data only changes when a new word moves in, so it holds under back-pressure.
    if (s1_valid_q && s2_free) out_data_d = combined;

    if (deliver && (count_q != '1)) count_d = count_q + CW'(1);

    case (state_q)
      ST_CFG: begin
        if (cfg_commit) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (cfg_reopen) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) state_d = ST_CFG;
      end
      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CFG;
      h_q        <= '{default: '0};
      p_q        <= '{default: '0};
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      count_q    <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      p_q        <= p_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      count_q    <= count_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_count = count_q;
  assign cfg_err   = cfg_err_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bmf_basis_decoder.sv
`default_nettype none
// Self-checking bench for bmf_basis_decoder: vector table, directed corner sequences,
// and a randomized stream scored against a queue-based reference model.
module tb_bmf_basis_decoder;
  localparam int K  = 3;
  localparam int M  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we, cfg_commit, cfg_reopen;
  logic [1:0]    cfg_row;
  logic [M-1:0]  cfg_data;
  logic          cfg_err;
  logic          in_valid, in_ready;
  logic [K-1:0]  in_code;
  logic          out_valid, out_ready;
  logic [M-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  bmf_basis_decoder #(.K(K), .M(M), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_reopen(cfg_reopen), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .state_o(state_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [M-1:0] mh [K];
  int           mstate, mcount, nstate, sz0;
  bit           merr, mon_en, hold_prev;
  logic [M-1:0] data_prev, e;
  logic [M-1:0] expq [$];

  function automatic logic [M-1:0] model_word(input logic [K-1:0] code);
    logic [M-1:0] acc = '0;
    for (int r = 0; r < K; r++)
      if (code[r]) begin
`ifdef BMF_GF2_EN
        acc = acc ^ mh[r];
`else
        acc = acc | mh[r];
`endif
      end
    return acc;
  endfunction

  task automatic rst_model();
    for (int r = 0; r < K; r++) mh[r] = '0;
    mstate = 0; mcount = 0; merr = 0; hold_prev = 0;
    expq.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("state", state_o, mstate);
      chk("out_count", out_count, mcount);
      chk("cfg_err", cfg_err, merr);
      if (mstate != 1) chk("in_ready_not_run", in_ready, 0);
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, data_prev);
      end
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
      sz0 = expq.size();
      nstate = mstate;
      if (mstate == 0 && cfg_commit) begin nstate = 1; mcount = 0; end
      else if (mstate == 1 && cfg_reopen) nstate = 2;
      else if (mstate == 2 && sz0 == 0) nstate = 0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = expq.pop_front();
          chk("out_data", out_data, e);
        end
        if (mcount < (2**CW - 1)) mcount++;
      end
      if (in_valid && in_ready) expq.push_back(model_word(in_code));
      if (cfg_we) begin
        if (mstate == 0 && cfg_row < K) mh[cfg_row] = cfg_data;
        else merr = 1;
      end
      mstate = nstate;
    end
  end

  task automatic cfg_write(input logic [1:0] row, input logic [M-1:0] data);
    cfg_we = 1; cfg_row = row; cfg_data = data;
    step();
    cfg_we = 0;
  endtask

  typedef struct {
    logic [K-1:0] code;
    logic [M-1:0] exp;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'd0, 4'b0000}; tbl[1] = '{3'd1, 4'b0011};
    tbl[2] = '{3'd2, 4'b0100}; tbl[3] = '{3'd3, 4'b0111};
    tbl[4] = '{3'd4, 4'b1000}; tbl[5] = '{3'd5, 4'b1011};
    tbl[6] = '{3'd6, 4'b1100}; tbl[7] = '{3'd7, 4'b1111};

    in_valid = 0; in_code = '0; out_ready = 1; cfg_we = 0; cfg_row = '0;
    cfg_data = '0; cfg_commit = 0; cfg_reopen = 0; mon_en = 0;
    rst_model();
    rst_n = 0;
    repeat (2) step();
    chk("rst_state", state_o, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1;
    step();
    mon_en = 1;

    // Basis load; last row written in the same cycle as commit
    cfg_write(2'd0, 4'b0011);
    cfg_write(2'd1, 4'b0100);
    cfg_we = 1; cfg_row = 2'd2; cfg_data = 4'b1000; cfg_commit = 1;
    step();
    cfg_we = 0; cfg_commit = 0;
    chk("commit_state", state_o, 1);

    // Two-cycle latency
    in_valid = 1; in_code = 3'b101;
    step();
    in_valid = 0;
    chk("lat1_valid", out_valid, 0);
    step();
    chk("lat2_valid", out_valid, 1);
    chk("lat2_data", out_data, 4'b1011);
    step();

    // Table stream, one word per cycle
    for (int s = 1; s <= 10; s++) begin
      if (s <= 8) begin in_valid = 1; in_code = tbl[s-1].code; end
      else in_valid = 0;
      step();
      if (s >= 2 && s <= 9) begin
        chk("tbl_valid", out_valid, 1);
        chk("tbl_data", out_data, tbl[s-2].exp);
      end
    end
    chk("stream_count", out_count, 9);

    // Back-pressure: pipe fills after two accepts
    out_ready = 0; in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      in_code = K'($urandom);
      step();
      if (c >= 1) chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1; in_valid = 0;
    repeat (4) step();
    chk("bp_drained", expq.size(), 0);

    // Write attempt in RUN is dropped and flagged
    cfg_write(2'd0, 4'b1111);
    chk("run_we_err", cfg_err, 1);
    in_valid = 1; in_code = 3'b001;
    step();
    in_valid = 0;
    step();
    chk("run_we_h", out_data, 4'b0011);
    step();

    // Reopen with two words in flight
    in_valid = 1; in_code = 3'b011;
    step();
    in_code = 3'b110;
    step();
    in_valid = 0; out_ready = 0; cfg_reopen = 1;
    step();
    cfg_reopen = 0;
    chk("drain_state", state_o, 2);
    chk("drain_in_ready", in_ready, 0);
    out_ready = 1;
    begin
      int n = 0;
      while (state_o != 2'd0 && n < 10) begin step(); n++; end
      if (n >= 10) chk("drain_timeout", state_o, 0);
    end
    chk("drain_count", out_count, 14);

    // New basis, recommit
    cfg_write(2'd0, 4'b0110);
    cfg_write(2'd1, 4'b0011);
    cfg_write(2'd2, 4'b1001);
    cfg_commit = 1;
    step();
    cfg_commit = 0;
    chk("recommit_count", out_count, 0);
    in_valid = 1; in_code = 3'b011;
    step();
    in_valid = 0;
    step();
`ifdef BMF_GF2_EN
    chk("combine_011", out_data, 4'b0101);
`else
    chk("combine_011", out_data, 4'b0111);
`endif
    step();

    // Randomized stream against the model
    for (int c = 0; c < 80; c++) begin
      in_valid = 1'($urandom); in_code = K'($urandom); out_ready = 1'($urandom);
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (4) step();
    chk("rand_drained", expq.size(), 0);

    // Asynchronous reset with a full pipe
    out_ready = 0; in_valid = 1;
    repeat (3) begin in_code = K'($urandom); step(); end
    #2;
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_state", state_o, 0);
    chk("arst_count", out_count, 0);
    chk("arst_in_ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    rst_model();
    step();
    rst_n = 1;
    step();
    mon_en = 1;

    // Out-of-range row is dropped; cleared H decodes to zero
    cfg_write(2'd3, 4'b1111);
    chk("row3_err", cfg_err, 1);
    cfg_commit = 1;
    step();
    cfg_commit = 0;
    in_valid = 1; in_code = 3'b111;
    step();
    in_valid = 0;
    step();
    chk("cleared_h_valid", out_valid, 1);
    chk("cleared_h_data", out_data, 4'b0000);
    repeat (3) step();

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
